micro_sequencer: RTL and testbench



---
 rtl/micro_sequencer.sv | 147 ++++++++++++++
 tb/tb_micro_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Micro-program sequencer: drives the control-store address and decodes microinstructions.
// Optional USEQ_CYCLE_COUNT_EN adds a saturating commit counter on port ucount.
module micro_sequencer #(
    parameter int unsigned          UADDR_W     = 8,
    parameter logic [UADDR_W-1:0]   RESET_UADDR = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [30:0]        mir,
    input  logic               z_flag,
    input  logic [UADDR_W-1:0] mbru,
    input  logic               mem_ready,
    output logic [UADDR_W-1:0] upc,
    output logic [3:0]         alu_op,
    output logic [8:0]         reg_we,
    output logic [2:0]         mem_ctrl,
    output logic               inc_en,
    output logic [3:0]         bus_sel,
    output logic               busy,
    output logic               halted
`ifdef USEQ_CYCLE_COUNT_EN
    ,
    output logic [15:0]        ucount
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT_MEM,
        S_HALT
    } state_t;

    localparam logic [1:0] MODE_JUMP   = 2'b00;
    localparam logic [1:0] MODE_DISP   = 2'b01;
    localparam logic [1:0] MODE_HALT   = 2'b10;

    state_t               state_q, state_d;
    logic [7:0]           next_q;
    logic [1:0]           mode_q;
    logic [8:0]           we_q;
    logic [UADDR_W-1:0]   upc_d;
    logic [3:0]           alu_op_d, bus_sel_d;
    logic [2:0]           mem_ctrl_d;
    logic                 inc_en_d;
    logic                 commit;
    logic                 accept_start;
    logic                 mem_req;

    // A read or write in the latched microinstruction must see mem_ready before committing
    assign mem_req = mem_ctrl[2] | mem_ctrl[1];

    always_comb begin
        state_d      = state_q;
        upc_d        = upc;
        alu_op_d     = alu_op;
        mem_ctrl_d   = mem_ctrl;
        inc_en_d     = inc_en;
        bus_sel_d    = bus_sel;
        reg_we       = '0;
        commit       = 1'b0;
        accept_start = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    accept_start = 1'b1;
                    upc_d        = RESET_UADDR;
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d    = S_EXEC;
                alu_op_d   = mir[20:17];
                mem_ctrl_d = mir[7:5];
                inc_en_d   = mir[4];
                bus_sel_d  = mir[3:0];
            end
            S_EXEC, S_WAIT_MEM: begin
                if (mem_req && !mem_ready) begin
                    state_d = S_WAIT_MEM;
                end else begin
                    commit     = 1'b1;
                    reg_we     = we_q;
                    alu_op_d   = '0;
                    mem_ctrl_d = '0;
                    inc_en_d   = 1'b0;
                    bus_sel_d  = '0;
                    state_d    = S_FETCH;
                    case (mode_q)
                        MODE_JUMP: upc_d = UADDR_W'(next_q);
                        MODE_DISP: upc_d = mbru;
                        MODE_HALT: state_d = S_HALT;
                        default:   upc_d = z_flag ? UADDR_W'(next_q)
                                                  : UADDR_W'(8'(next_q + 8'd1));
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            upc      <= RESET_UADDR;
            alu_op   <= '0;
            mem_ctrl <= '0;
            inc_en   <= 1'b0;
            bus_sel  <= '0;
            next_q   <= '0;
            mode_q   <= '0;
            we_q     <= '0;
            busy     <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state_q  <= state_d;
            upc      <= upc_d;
            alu_op   <= alu_op_d;
            mem_ctrl <= mem_ctrl_d;
            inc_en   <= inc_en_d;
            bus_sel  <= bus_sel_d;
            busy     <= (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_WAIT_MEM);
            halted   <= (state_d == S_HALT);
            // Latched here so a stall does not depend on mir after FETCH
            if (state_q == S_FETCH) begin
                next_q <= mir[30:23];
                mode_q <= mir[22:21];
                we_q   <= mir[16:8];
            end
        end
    end

`ifdef USEQ_CYCLE_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ucount <= '0;
        end else if (accept_start) begin
            ucount <= '0;
        end else if (commit && (ucount != 16'hFFFF)) begin
            ucount <= ucount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: vector table plus scoreboard of commit results.
module tb_micro_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [30:0] mir;
    logic        z_flag;
    logic [7:0]  mbru;
    logic        mem_ready;
    logic [7:0]  upc;
    logic [3:0]  alu_op;
    logic [8:0]  reg_we;
    logic [2:0]  mem_ctrl;
    logic        inc_en;
    logic [3:0]  bus_sel;
    logic        busy;
    logic        halted;
`ifdef USEQ_CYCLE_COUNT_EN
    logic [15:0] ucount;
`endif

    micro_sequencer #(.UADDR_W(8), .RESET_UADDR(8'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mir       (mir),
        .z_flag    (z_flag),
        .mbru      (mbru),
        .mem_ready (mem_ready),
        .upc       (upc),
        .alu_op    (alu_op),
        .reg_we    (reg_we),
        .mem_ctrl  (mem_ctrl),
        .inc_en    (inc_en),
        .bus_sel   (bus_sel),
        .busy      (busy),
        .halted    (halted)
`ifdef USEQ_CYCLE_COUNT_EN
        ,
        .ucount    (ucount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [30:0] word;
        logic        z;
        logic [7:0]  mbru;
        int          rdy_lo;
        int          exp_stall;
        logic [7:0]  exp_upc;
    } vec_t;

    typedef struct {
        logic [8:0] we;
        logic [7:0] upc;
        logic       halt;
    } exp_t;

    vec_t  vecs [9];
    exp_t  sb [$];
    int    n_cmp;
    int    n_fail;
    logic [7:0] cur_upc;

    function automatic logic [30:0] mk(input logic [7:0] nxt, input logic [1:0] mode,
                                       input logic [3:0] alu, input logic [8:0] we,
                                       input logic [2:0] mem, input logic inc,
                                       input logic [3:0] bus);
        return {nxt, mode, alu, we, mem, inc, bus};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_dp_zero(input string tag);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        chk({tag, "_reg_we"}, 32'(reg_we), 32'd0);
        chk({tag, "_mem_ctrl"}, 32'(mem_ctrl), 32'd0);
        chk({tag, "_inc_en"}, 32'(inc_en), 32'd0);
        chk({tag, "_bus_sel"}, 32'(bus_sel), 32'd0);
    endtask

    // Called just after a falling edge while the DUT is in FETCH
    task automatic run_vec(input int i);
        vec_t v;
        exp_t e;
        exp_t got;
        int   c;
        bit   done;
        v         = vecs[i];
        mir       = v.word;
        z_flag    = v.z;
        mbru      = v.mbru;
        mem_ready = (v.rdy_lo == 0);
        start     = i[0];
        #1;
        chk($sformatf("v%0d_fetch_upc", i), 32'(upc), 32'(cur_upc));
        chk($sformatf("v%0d_fetch_busy", i), 32'(busy), 32'd1);
        chk_dp_zero($sformatf("v%0d_fetch", i));
        e.we   = v.word[16:8];
        e.upc  = v.exp_upc;
        e.halt = (v.word[22:21] == 2'b10);
        sb.push_back(e);
        got  = e;
        @(negedge clk);
        c    = 0;
        done = 1'b0;
        while (!done && c < 20) begin
            mem_ready = (c >= v.rdy_lo);
            if (c > 0) mir = 31'($urandom);
            #1;
            chk($sformatf("v%0d_c%0d_alu_op", i, c), 32'(alu_op), 32'(v.word[20:17]));
            chk($sformatf("v%0d_c%0d_mem_ctrl", i, c), 32'(mem_ctrl), 32'(v.word[7:5]));
            chk($sformatf("v%0d_c%0d_inc_en", i, c), 32'(inc_en), 32'(v.word[4]));
            chk($sformatf("v%0d_c%0d_bus_sel", i, c), 32'(bus_sel), 32'(v.word[3:0]));
            chk($sformatf("v%0d_c%0d_busy", i, c), 32'(busy), 32'd1);
            if (c == v.exp_stall) begin
                if (sb.size() == 0) begin
                    chk($sformatf("v%0d_sb_empty", i), 32'd0, 32'd1);
                end else begin
                    got = sb.pop_front();
                    chk($sformatf("v%0d_commit_reg_we", i), 32'(reg_we), 32'(got.we));
                end
                done = 1'b1;
            end else begin
                chk($sformatf("v%0d_c%0d_stall_reg_we", i, c), 32'(reg_we), 32'd0);
                chk($sformatf("v%0d_c%0d_stall_upc", i, c), 32'(upc), 32'(cur_upc));
            end
            @(negedge clk);
            c++;
        end
        if (!done) chk($sformatf("v%0d_commit_timeout", i), 32'd0, 32'd1);
        mem_ready = 1'b0;
        start     = 1'b0;
        #1;
        chk($sformatf("v%0d_next_upc", i), 32'(upc), 32'(got.upc));
        chk($sformatf("v%0d_post_halted", i), 32'(halted), 32'(got.halt));
        chk($sformatf("v%0d_post_busy", i), 32'(busy), 32'(!got.halt));
        chk_dp_zero($sformatf("v%0d_post", i));
        cur_upc = got.upc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        vecs[0] = '{mk(8'd1,   2'b00, 4'h3, 9'h001, 3'b000, 1'b1, 4'h5), 1'b0, 8'h00, 0, 0, 8'd1};
        vecs[1] = '{mk(8'hAA,  2'b01, 4'hA, 9'h1FF, 3'b000, 1'b0, 4'hC), 1'b1, 8'd29, 0, 0, 8'd29};
        vecs[2] = '{mk(8'd23,  2'b11, 4'h5, 9'h010, 3'b000, 1'b1, 4'h1), 1'b1, 8'h55, 0, 0, 8'd23};
        vecs[3] = '{mk(8'd23,  2'b11, 4'h6, 9'h020, 3'b000, 1'b0, 4'h2), 1'b0, 8'h55, 0, 0, 8'd24};
        vecs[4] = '{mk(8'd255, 2'b11, 4'h7, 9'h100, 3'b000, 1'b1, 4'h3), 1'b0, 8'h00, 0, 0, 8'd0};
        vecs[5] = '{mk(8'h80,  2'b00, 4'h9, 9'h0A5, 3'b100, 1'b0, 4'h7), 1'b0, 8'h00, 3, 3, 8'h80};
        vecs[6] = '{mk(8'h42,  2'b00, 4'hB, 9'h05A, 3'b010, 1'b1, 4'h8), 1'b0, 8'h00, 1, 1, 8'h42};
        vecs[7] = '{mk(8'h10,  2'b00, 4'hC, 9'h003, 3'b001, 1'b0, 4'hF), 1'b0, 8'h00, 2, 0, 8'h10};
        vecs[8] = '{mk(8'h77,  2'b10, 4'hD, 9'h0C0, 3'b000, 1'b1, 4'h4), 1'b0, 8'h00, 0, 0, 8'h10};

        rst       = 1'b1;
        start     = 1'b0;
        mir       = '0;
        z_flag    = 1'b0;
        mbru      = '0;
        mem_ready = 1'b0;
        cur_upc   = 8'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_upc", 32'(upc), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk_dp_zero("reset");
`ifdef USEQ_CYCLE_COUNT_EN
        chk("reset_ucount", 32'(ucount), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        @(negedge clk);
        #1;
        chk("start_upc", 32'(upc), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);

        for (int i = 0; i < 9; i++) run_vec(i);

`ifdef USEQ_CYCLE_COUNT_EN
        chk("ucount_after_program", 32'(ucount), 32'd9);
`endif
        // HALT holds until start, then restarts from the reset address
        @(negedge clk);
        #1;
        chk("halt_hold_halted", 32'(halted), 32'd1);
        chk("halt_hold_upc", 32'(upc), 32'h10);
        chk_dp_zero("halt_hold");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("restart_upc", 32'(upc), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_halted", 32'(halted), 32'd0);
`ifdef USEQ_CYCLE_COUNT_EN
        chk("restart_ucount", 32'(ucount), 32'd0);
`endif

        // Reset in the middle of a memory stall discards the pending commit
        mir       = mk(8'h33, 2'b00, 4'h1, 9'h001, 3'b100, 1'b0, 4'h1);
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rstwait_busy", 32'(busy), 32'd1);
        chk("rstwait_mem_ctrl", 32'(mem_ctrl), 32'd4);
        chk("rstwait_reg_we", 32'(reg_we), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rstwait_after_upc", 32'(upc), 32'd0);
        chk("rstwait_after_busy", 32'(busy), 32'd0);
        chk("rstwait_after_halted", 32'(halted), 32'd0);
        chk_dp_zero("rstwait_after");
`ifdef USEQ_CYCLE_COUNT_EN
        chk("rstwait_ucount", 32'(ucount), 32'd0);
`endif
        rst       = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rstwait_idle_busy", 32'(busy), 32'd0);
        chk("rstwait_idle_upc", 32'(upc), 32'd0);
        chk("rstwait_idle_reg_we", 32'(reg_we), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
